regfile_scb: RTL and testbench
==============================

REGFILE_SCB -- requirements
Module: regfile_scb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 The block SHALL have parameter RFIDX_WIDTH, default 5, register index width; depth = 2**RFIDX_WIDTH.
REQ-003 The block SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 The block SHALL have parameter NWR, default 2, number of write ports (1..2).
REQ-005 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port rd_addr  input  NRD*RFIDX_WIDTH  read indices, port p at bits [p*RFIDX_WIDTH +: RFIDX_WIDTH].
REQ-008 The block SHALL have port rd_data  output  NRD*XLEN  read data, port p at [p*XLEN +: XLEN].
REQ-009 The block SHALL have port rd_busy  output  NRD  per-read-port scoreboard pending flag.
REQ-010 The block SHALL have port wr_en  input  NWR  per-port write enable.
REQ-011 The block SHALL have port wr_addr  input  NWR*RFIDX_WIDTH  write indices.
REQ-012 The block SHALL have port wr_data  input  NWR*XLEN  write data.
REQ-013 The block SHALL have port alloc_en  input  1  request to mark a destination register pending.
REQ-014 The block SHALL have port alloc_addr  input  RFIDX_WIDTH  destination index for allocation.
REQ-015 The block SHALL have port alloc_ok  output  1  allocation accepted this cycle.
REQ-016 The block SHALL have port busy_vec  output  2**RFIDX_WIDTH  registered scoreboard state.

Function
REQ-017 Reads SHALL be combinational (zero latency) from rd_addr to rd_data and rd_busy.
REQ-018 Index 0 SHALL read as all-zero, SHALL ignore writes, and SHALL never be busy.
REQ-019 Writes SHALL update the array on the rising clk edge when wr_en[w]=1 and wr_addr[w]!=0.
REQ-020 Same-cycle writes to the same nonzero index SHALL resolve with the highest-numbered port winning.
REQ-021 A read whose index matches an enabled same-cycle nonzero write SHALL return that write data (write-through bypass), using the REQ-020 priority.
REQ-022 A scoreboard bit SHALL be cleared at the edge where any enabled write targets that index.
REQ-023 alloc_ok SHALL be alloc_en & (alloc_addr!=0) & (busy_vec[alloc_addr]==0 | a same-cycle enabled write targets alloc_addr).
REQ-024 When alloc_ok=1, busy_vec[alloc_addr] SHALL be set at the next edge; set SHALL take precedence over the clear in REQ-022.
REQ-025 alloc_en to index 0 SHALL yield alloc_ok=0 and change no state.
REQ-026 alloc_en to a busy index with no same-cycle write SHALL yield alloc_ok=0 (stall) and change no state.
REQ-027 rd_busy[p] SHALL equal busy_vec[rd_addr[p]] with the same-cycle write clear applied (bypassed), and SHALL be 0 for index 0.

Reset
REQ-028 While rst_n=0, all registers SHALL be 0 and busy_vec SHALL be all-zero, taking effect asynchronously.
REQ-029 rd_data SHALL read 0 for every index during and after reset until written.
REQ-030 A write or allocation coinciding with reset deassertion SHALL take effect only at the first rising edge with rst_n=1 sampled high.

Structure
REQ-031 XLEN and RFIDX_WIDTH defaults SHALL come from the shared defines file; no new package typedefs are required.
REQ-032 The scoreboard SHALL be the sub-module regfile_scoreboard (busy_vec state, alloc_ok, clear logic); the array and bypass mux SHALL stay in regfile_scb.

Verification
REQ-033 Reset, then read all 32 indices -> every rd_data=0, busy_vec=0.
REQ-034 Write x5=0xDEADBEEF on port 0, read x5 on port 1 the same cycle -> 0xDEADBEEF bypassed; the next cycle still reads 0xDEADBEEF.
REQ-035 Both write ports target x7 (port0=0x11, port1=0x22) -> x7=0x22; a write of 0xFF to x0 -> x0 still reads 0.
REQ-036 alloc x9 -> busy_vec[9]=1; re-alloc x9 -> alloc_ok=0; write x9 -> busy cleared; write x9 and alloc x9 in the same cycle -> alloc_ok=1 and busy_vec[9]=1.
REQ-037 Assert rst_n=0 mid-operation with x3=0x1234 and busy_vec[3]=1 -> immediately x3=0 and busy_vec=0 without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_scb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_scb_pkg
// Shared defaults for the register file / scoreboard slice.
//   XLEN_DEFAULT        : data width in bits
//   RFIDX_WIDTH_DEFAULT : register index width (depth = 2**RFIDX_WIDTH)
//   NRD_DEFAULT         : number of combinational read ports (1..4)
//   NWR_DEFAULT         : number of write ports (1..2)
// ---------------------------------------------------------------------------
package regfile_scb_pkg;

    localparam int XLEN_DEFAULT        = 32;
    localparam int RFIDX_WIDTH_DEFAULT = 5;
    localparam int NRD_DEFAULT         = 2;
    localparam int NWR_DEFAULT         = 2;

endpackage

// File: rtl/regfile_scb_if.sv
// ---------------------------------------------------------------------------
// regfile_scb_if
// Bundles the read, write and allocation signals of regfile_scb.
//   rd_addr/rd_data/rd_busy : NRD packed read ports (port p at slice p)
//   wr_en/wr_addr/wr_data   : NWR packed write ports
//   alloc_en/alloc_addr     : destination allocation request
//   alloc_ok                : allocation accepted this cycle
//   busy_vec                : registered scoreboard state, one bit per index
// master = the block driving requests, slave = regfile_scb.
// ---------------------------------------------------------------------------
interface regfile_scb_if
    import regfile_scb_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int RFIDX_WIDTH = RFIDX_WIDTH_DEFAULT,
    parameter int NRD         = NRD_DEFAULT,
    parameter int NWR         = NWR_DEFAULT
) ();

    logic [NRD*RFIDX_WIDTH-1:0] rd_addr;
    logic [NRD*XLEN-1:0]        rd_data;
    logic [NRD-1:0]             rd_busy;
    logic [NWR-1:0]             wr_en;
    logic [NWR*RFIDX_WIDTH-1:0] wr_addr;
    logic [NWR*XLEN-1:0]        wr_data;
    logic                       alloc_en;
    logic [RFIDX_WIDTH-1:0]     alloc_addr;
    logic                       alloc_ok;
    logic [2**RFIDX_WIDTH-1:0]  busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_busy, alloc_ok, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_busy, alloc_ok, busy_vec
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Tracks which registers have an outstanding producer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en/addr  : write ports; an enabled write clears its index
//   rd_addr     : read indices, used for the bypassed rd_busy lookup
//   alloc_en/ad : allocation request; sets the index busy when accepted
//   alloc_ok    : allocation accepted this cycle
//   rd_busy     : per read port pending flag (same-cycle clears applied)
//   busy_vec    : registered busy state
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_scb_pkg::*;
#(
    parameter int RFIDX_WIDTH = RFIDX_WIDTH_DEFAULT,
    parameter int NRD         = NRD_DEFAULT,
    parameter int NWR         = NWR_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NWR-1:0]             wr_en,
    input  logic [NWR*RFIDX_WIDTH-1:0] wr_addr,
    input  logic [NRD*RFIDX_WIDTH-1:0] rd_addr,
    input  logic                       alloc_en,
    input  logic [RFIDX_WIDTH-1:0]     alloc_addr,
    output logic                       alloc_ok,
    output logic [NRD-1:0]             rd_busy,
    output logic [2**RFIDX_WIDTH-1:0]  busy_vec
);

    localparam int DEPTH = 2**RFIDX_WIDTH;

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] set_vec;

    // One bit per index targeted by any enabled write this cycle. Index 0
    // is masked so it can never influence allocation or read flags.
    always_comb begin
        clr_vec = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                clr_vec[wr_addr[w*RFIDX_WIDTH +: RFIDX_WIDTH]] = 1'b1;
            end
        end
        clr_vec[0] = 1'b0;
    end

    // A busy destination may be re-allocated when its producer writes back
    // in the same cycle: the old value retires and the new owner takes over.
    assign alloc_ok = alloc_en && (alloc_addr != '0) &&
                      (!busy_reg[alloc_addr] || clr_vec[alloc_addr]);

    always_comb begin
        set_vec = '0;
        if (alloc_ok) begin
            set_vec[alloc_addr] = 1'b1;
        end
    end

    // Set is OR-ed after the clear so a same-cycle allocation wins.
    assign busy_next = (busy_reg & ~clr_vec) | set_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_vec = busy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd_busy
            logic [RFIDX_WIDTH-1:0] idx;
            assign idx         = rd_addr[gi*RFIDX_WIDTH +: RFIDX_WIDTH];
            // busy_reg[0] is never set, so index 0 reads as not busy.
            assign rd_busy[gi] = busy_reg[idx] & ~clr_vec[idx];
        end
    endgenerate

endmodule

// File: rtl/regfile_scb.sv
// ---------------------------------------------------------------------------
// regfile_scb
// Multi-ported register file with write-through bypass and a busy
// scoreboard for destination allocation.
//   clk   : sole clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset, clears registers and busy bits
//   bus   : regfile_scb_if.slave (read ports, write ports, allocation,
//           busy_vec)
// Index 0 is hardwired to zero, ignores writes and is never busy. On
// same-cycle writes to one index the highest-numbered port wins, both for
// the array update and for the read bypass.
// ---------------------------------------------------------------------------
module regfile_scb
    import regfile_scb_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int RFIDX_WIDTH = RFIDX_WIDTH_DEFAULT,
    parameter int NRD         = NRD_DEFAULT,
    parameter int NWR         = NWR_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_scb_if.slave  bus
);

    localparam int DEPTH = 2**RFIDX_WIDTH;

    // Flop-based storage: asynchronous clear of every entry rules out a
    // block RAM mapping.
    logic [DEPTH-1:0][XLEN-1:0] mem_reg;
    logic [DEPTH-1:0][XLEN-1:0] mem_next;

    // Later ports overwrite earlier ones, giving highest-port priority.
    always_comb begin
        mem_next = mem_reg;
        for (int w = 0; w < NWR; w++) begin
            if (bus.wr_en[w] &&
                (bus.wr_addr[w*RFIDX_WIDTH +: RFIDX_WIDTH] != '0)) begin
                mem_next[bus.wr_addr[w*RFIDX_WIDTH +: RFIDX_WIDTH]] =
                    bus.wr_data[w*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_reg <= '0;
        end else begin
            mem_reg <= mem_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd_port
            logic [RFIDX_WIDTH-1:0] idx;
            logic [XLEN-1:0]        val;

            assign idx = bus.rd_addr[gi*RFIDX_WIDTH +: RFIDX_WIDTH];

            always_comb begin
                val = mem_reg[idx];
                for (int w = 0; w < NWR; w++) begin
                    if (bus.wr_en[w] &&
                        (bus.wr_addr[w*RFIDX_WIDTH +: RFIDX_WIDTH] == idx)) begin
                        val = bus.wr_data[w*XLEN +: XLEN];
                    end
                end
                if (idx == '0) begin
                    val = '0;
                end
            end

            assign bus.rd_data[gi*XLEN +: XLEN] = val;
        end
    endgenerate

    regfile_scoreboard #(
        .RFIDX_WIDTH (RFIDX_WIDTH),
        .NRD         (NRD),
        .NWR         (NWR)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .rd_addr    (bus.rd_addr),
        .alloc_en   (bus.alloc_en),
        .alloc_addr (bus.alloc_addr),
        .alloc_ok   (bus.alloc_ok),
        .rd_busy    (bus.rd_busy),
        .busy_vec   (bus.busy_vec)
    );

endmodule

// File: tb/tb_regfile_scb.sv
// ---------------------------------------------------------------------------
// tb_regfile_scb
// Directed scenarios followed by random traffic, checked against a
// behavioural register/busy model kept in plain arrays.
// ---------------------------------------------------------------------------
module tb_regfile_scb;

    localparam int XLEN  = 32;
    localparam int RW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regfile_scb_if #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_scb #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .NRD(NRD), .NWR(NWR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [XLEN-1:0] ref_reg  [DEPTH];
    bit              ref_busy [DEPTH];

    // Stimulus for the current cycle
    int              st_rd_a  [NRD];
    bit              st_wr_en [NWR];
    int              st_wr_a  [NWR];
    logic [XLEN-1:0] st_wr_d  [NWR];
    bit              st_al_en;
    int              st_al_a;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            ref_reg[i]  = '0;
            ref_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        for (int p = 0; p < NRD; p++) st_rd_a[p] = 0;
        for (int w = 0; w < NWR; w++) begin
            st_wr_en[w] = 1'b0;
            st_wr_a[w]  = 0;
            st_wr_d[w]  = '0;
        end
        st_al_en = 1'b0;
        st_al_a  = 0;
    endtask

    task automatic drive();
        for (int p = 0; p < NRD; p++) bus.rd_addr[p*RW +: RW] = RW'(st_rd_a[p]);
        for (int w = 0; w < NWR; w++) begin
            bus.wr_en[w]               = st_wr_en[w];
            bus.wr_addr[w*RW +: RW]    = RW'(st_wr_a[w]);
            bus.wr_data[w*XLEN +: XLEN] = st_wr_d[w];
        end
        bus.alloc_en   = st_al_en;
        bus.alloc_addr = RW'(st_al_a);
        #1;
    endtask

    // True when an enabled write this cycle lands on a real register a.
    function automatic bit written(input int a);
        bit hit = 1'b0;
        if (a != 0)
            for (int w = 0; w < NWR; w++)
                if (st_wr_en[w] && st_wr_a[w] == a) hit = 1'b1;
        return hit;
    endfunction

    // Value a reader sees now: newest write this cycle (highest port), else
    // stored value; register 0 is always zero.
    function automatic logic [XLEN-1:0] exp_rd(input int a);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        v = ref_reg[a];
        for (int w = 0; w < NWR; w++)
            if (st_wr_en[w] && st_wr_a[w] == a) v = st_wr_d[w];
        return v;
    endfunction

    function automatic bit exp_rd_busy(input int a);
        return (a != 0) && ref_busy[a] && !written(a);
    endfunction

    function automatic bit exp_alloc_ok();
        return st_al_en && (st_al_a != 0) && (!ref_busy[st_al_a] || written(st_al_a));
    endfunction

    function automatic logic [DEPTH-1:0] exp_busy_vec();
        logic [DEPTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i] = ref_busy[i];
        return v;
    endfunction

    task automatic check_model(input string tag);
        for (int p = 0; p < NRD; p++) begin
            check($sformatf("%s rd_data%0d x%0d", tag, p, st_rd_a[p]),
                  64'(bus.rd_data[p*XLEN +: XLEN]), 64'(exp_rd(st_rd_a[p])));
            check($sformatf("%s rd_busy%0d x%0d", tag, p, st_rd_a[p]),
                  64'(bus.rd_busy[p]), 64'(exp_rd_busy(st_rd_a[p])));
        end
        check($sformatf("%s alloc_ok", tag), 64'(bus.alloc_ok), 64'(exp_alloc_ok()));
        check($sformatf("%s busy_vec", tag), 64'(bus.busy_vec), 64'(exp_busy_vec()));
    endtask

    // Advance one clock edge and apply the architectural effect to the model.
    task automatic tick();
        bit ok;
        bit clr [DEPTH];
        ok = exp_alloc_ok();
        for (int i = 0; i < DEPTH; i++) clr[i] = written(i);
        @(posedge clk);
        for (int w = 0; w < NWR; w++)
            if (st_wr_en[w] && st_wr_a[w] != 0) ref_reg[st_wr_a[w]] = st_wr_d[w];
        for (int i = 0; i < DEPTH; i++)
            if (clr[i]) ref_busy[i] = 1'b0;
        if (ok) ref_busy[st_al_a] = 1'b1;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        idle();
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;

        // Every index reads zero and nothing is busy while held in reset.
        for (int i = 0; i < DEPTH / NRD; i++) begin
            st_rd_a[0] = 2 * i;
            st_rd_a[1] = 2 * i + 1;
            drive();
            check($sformatf("reset rd x%0d", 2 * i), 64'(bus.rd_data[0 +: XLEN]), 64'd0);
            check($sformatf("reset rd x%0d", 2 * i + 1), 64'(bus.rd_data[XLEN +: XLEN]), 64'd0);
            check("reset busy_vec", 64'(bus.busy_vec), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bypass: write x5 on port 0, read it on port 1 in the same cycle.
        idle();
        st_wr_en[0] = 1'b1; st_wr_a[0] = 5; st_wr_d[0] = 32'hDEADBEEF;
        st_rd_a[1] = 5;
        drive();
        check_model("bypass");
        check("bypass x5 const", 64'(bus.rd_data[XLEN +: XLEN]), 64'hDEADBEEF);
        tick();
        idle();
        st_rd_a[0] = 5; st_rd_a[1] = 5;
        drive();
        check_model("x5 held");
        check("x5 held const", 64'(bus.rd_data[0 +: XLEN]), 64'hDEADBEEF);
        tick();

        // Both ports write x7: port 1 wins, for bypass and for storage.
        idle();
        st_wr_en[0] = 1'b1; st_wr_a[0] = 7; st_wr_d[0] = 32'h11;
        st_wr_en[1] = 1'b1; st_wr_a[1] = 7; st_wr_d[1] = 32'h22;
        st_rd_a[0] = 7;
        drive();
        check_model("dual wr");
        check("dual wr bypass const", 64'(bus.rd_data[0 +: XLEN]), 64'h22);
        tick();
        idle();
        st_wr_en[0] = 1'b1; st_wr_a[0] = 0; st_wr_d[0] = 32'hFF;
        st_rd_a[0] = 7; st_rd_a[1] = 0;
        drive();
        check_model("x0 wr");
        check("x7 stored const", 64'(bus.rd_data[0 +: XLEN]), 64'h22);
        check("x0 bypass const", 64'(bus.rd_data[XLEN +: XLEN]), 64'd0);
        tick();
        idle();
        drive();
        check("x0 after wr const", 64'(bus.rd_data[0 +: XLEN]), 64'd0);

        // Scoreboard sequence on x9.
        idle();
        st_al_en = 1'b1; st_al_a = 9; st_rd_a[0] = 9;
        drive();
        check_model("alloc x9");
        check("alloc x9 ok const", 64'(bus.alloc_ok), 64'd1);
        tick();
        drive();
        check_model("realloc x9");
        check("x9 busy const", 64'(bus.busy_vec[9]), 64'd1);
        check("realloc x9 stall const", 64'(bus.alloc_ok), 64'd0);
        tick();
        idle();
        st_wr_en[1] = 1'b1; st_wr_a[1] = 9; st_wr_d[1] = 32'hA5A5;
        st_rd_a[0] = 9;
        drive();
        check_model("wb x9");
        check("wb x9 rd_busy const", 64'(bus.rd_busy[0]), 64'd0);
        tick();
        idle();
        drive();
        check("x9 cleared const", 64'(bus.busy_vec[9]), 64'd0);
        st_al_en = 1'b1; st_al_a = 9;
        drive();
        tick();
        idle();
        st_wr_en[0] = 1'b1; st_wr_a[0] = 9; st_wr_d[0] = 32'h5A5A;
        st_al_en = 1'b1; st_al_a = 9;
        drive();
        check_model("wb+alloc x9");
        check("wb+alloc x9 ok const", 64'(bus.alloc_ok), 64'd1);
        tick();
        idle();
        st_al_en = 1'b1; st_al_a = 0;
        drive();
        check_model("alloc x0");
        check("x9 still busy const", 64'(bus.busy_vec[9]), 64'd1);
        tick();

        // Asynchronous reset mid-cycle with live state in x3.
        idle();
        st_wr_en[0] = 1'b1; st_wr_a[0] = 3; st_wr_d[0] = 32'h1234;
        st_al_en = 1'b1; st_al_a = 3;
        drive();
        tick();
        idle();
        st_rd_a[0] = 3;
        drive();
        check_model("pre-reset");
        check("pre-reset x3 const", 64'(bus.rd_data[0 +: XLEN]), 64'h1234);
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("async rst x3", 64'(bus.rd_data[0 +: XLEN]), 64'd0);
        check("async rst busy_vec", 64'(bus.busy_vec), 64'd0);
        check_model("in reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic concentrated on a few indices to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int w = 0; w < NWR; w++) begin
                st_wr_en[w] = ($urandom_range(0, 1) == 1);
                st_wr_a[w]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                          : int'($urandom_range(0, 7));
                st_wr_d[w]  = $urandom;
            end
            for (int p = 0; p < NRD; p++) begin
                if ($urandom_range(0, 2) == 0)
                    st_rd_a[p] = st_wr_a[$urandom_range(0, NWR - 1)];
                else
                    st_rd_a[p] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                             : int'($urandom_range(0, 7));
            end
            st_al_en = ($urandom_range(0, 1) == 1);
            st_al_a  = ($urandom_range(0, 2) == 0) ? st_wr_a[$urandom_range(0, NWR - 1)]
                                                   : int'($urandom_range(0, 7));
            drive();
            check_model($sformatf("rnd%0d", n));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
